// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory: access sizes, FSM states and the
// alignment rule applied when DMEM_MISALIGN_CHECK_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } dmem_state_e;

    // Reserved size 2'b11 counts as misaligned so it is rejected with the same error path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = lane[0];
            MEM_W:   bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: extracts and extends load data from a word, and
// merges sub-word store data into an old word.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        zero_ext,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = old_word[{lane, 3'b000} +: 8];
    assign sel_half = lane[1] ? old_word[31:16] : old_word[15:0];

    // Halves look only at lane[1] and words ignore the lane, which force-aligns
    // misaligned accesses; size 2'b11 takes the word path.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        load_data  = old_word;
        merge_data = wdata;
        case (size)
            MEM_B: begin
                load_data  = {{24{~zero_ext & sel_byte[7]}}, sel_byte};
                merge_data = old_word;
                merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            MEM_H: begin
                load_data  = {{16{~zero_ext & sel_half[15]}}, sel_half};
                merge_data = lane[1] ? {wdata[15:0], old_word[15:0]}
                                     : {old_word[31:16], wdata[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed RV32I data memory with B/H/W accesses, registered responses
// and read-modify-write for sub-word stores. Option: DMEM_MISALIGN_CHECK_EN.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // NOTE: the array has no reset; rst must not clear memory, and a reset port would block block-RAM inference.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    dmem_state_e      state, state_next;
    logic             accept, acc_err, acc_sub;
    logic             mem_we;
    logic [IDX_W-1:0] acc_idx, op_idx, mem_waddr;
    logic [31:0]      mem_wdata, rd_word, op_wdata;
    logic [31:0]      load_data, merge_data;
    logic [1:0]       op_size, op_lane;
    logic             op_zext, rsp_load, rsp_err_q;
    logic             unused_addr_hi;

    assign acc_idx        = req_addr[IDX_W+1:2];
    assign acc_sub        = (req_size == MEM_B) || (req_size == MEM_H);
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign acc_err = is_misaligned(req_size, req_addr[1:0]);
`else
    assign acc_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = acc_idx;
        mem_wdata  = req_wdata;
        case (state)
            IDLE: begin
                req_ready = ~rst;
                accept    = req_valid & ~rst;
                if (accept && !acc_err && req_we) begin
                    if (acc_sub) state_next = MERGE;
                    else         mem_we     = 1'b1;
                end
            end
            MERGE: begin
                mem_we     = 1'b1;
                mem_waddr  = op_idx;
                mem_wdata  = merge_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read-before-write port: rd_word holds the addressed word for exactly one
    // cycle, which is all a load response or a MERGE write needs.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_word <= mem[acc_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_load  <= 1'b0;
            rsp_err_q <= 1'b0;
            op_idx    <= '0;
            op_size   <= '0;
            op_lane   <= '0;
            op_zext   <= 1'b0;
            op_wdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_load  <= 1'b0;
            rsp_err_q <= 1'b0;
            if (accept) begin
                op_idx   <= acc_idx;
                op_size  <= req_size;
                op_lane  <= req_addr[1:0];
                op_zext  <= req_unsigned;
                op_wdata <= req_wdata;
                if (acc_err) begin
                    rsp_valid <= 1'b1;
                    rsp_err_q <= 1'b1;
                end else if (!req_we) begin
                    rsp_valid <= 1'b1;
                    rsp_load  <= 1'b1;
                end else if (!acc_sub) begin
                    rsp_valid <= 1'b1;
                end
            end
            if (state == MERGE) rsp_valid <= 1'b1;
        end
    end

    dmem_align u_align (
        .old_word   (rd_word),
        .wdata      (op_wdata),
        .size       (op_size),
        .lane       (op_lane),
        .zero_ext   (op_zext),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign rsp_rdata = rsp_load ? load_data : 32'h0;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: directed scenarios plus random traffic
// against a byte-array reference model; honours DMEM_MISALIGN_CHECK_EN.
module tb_dmem_sized;

    localparam int DEPTH  = 64;
    localparam int AW     = 32;
    localparam int NBYTES = DEPTH * 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    always #5 clk = ~clk;

    dmem_sized #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  ref_mem [NBYTES];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-level model: memory is a flat byte array addressed modulo its size.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output bit two_step);
        int unsigned n;
        int unsigned base;
        logic [31:0] val;
        rdata    = 32'h0;
        err      = 1'b0;
        two_step = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) begin
            err = 1'b1;
            return;
        end
`endif
        case (size)
            2'b00:   begin n = 1; base = addr; end
            2'b01:   begin n = 2; base = addr & ~32'd1; end
            default: begin n = 4; base = addr & ~32'd3; end
        endcase
        if (we) begin
            for (int i = 0; i < int'(n); i++) ref_mem[(base + i) % NBYTES] = wdata[8*i +: 8];
            two_step = (n < 4);
        end else begin
            val = 32'h0;
            for (int i = 0; i < int'(n); i++) val[8*i +: 8] = ref_mem[(base + i) % NBYTES];
            if (n < 4 && !uns && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
            rdata = val;
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit expect_rsp);
        int   waited;
        exp_t e;
        bit   two_step;
        waited       = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout addr=0x%08h ready=%0b required=1", addr, req_ready);
            req_valid = 1'b0;
            return;
        end
        if (expect_rsp) begin
            ref_access(we, size, uns, addr, wdata, e.rdata, e.err, two_step);
            e.due = cyc + (two_step ? 2 : 1);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_rsp due_cycle=%0d now=%0d", e.due, cyc);
        end
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp rdata=0x%08h err=%0b required=no response", rsp_rdata, rsp_err);
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata;

        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Word store then load, back to back.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);

        // Byte store: one bubble on req_ready while the merge is written.
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA, 1'b1);
        @(negedge clk);
        check("merge_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1);

        // Half store and half/word loads.
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);

        // Misaligned word load, then confirm memory untouched.
        issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        drain();

        // Reset during MERGE drops the pending write and its response.
        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055, 1'b0);
        rst = 1'b1;
        #1;
        check("ready_in_reset", 32'(req_ready), 32'd0);
        check("merge_rsp_dropped", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_merge_reset", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        drain();

        // Reset with a load response on the output drops that response.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        check("pending_rsp_dropped", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Address aliasing beyond the array depth.
        issue(1'b1, 2'b10, 1'b0, DEPTH * 4 + 32'h20, 32'hCAFEF00D, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);

        // Random traffic in a small window with random aliasing upper bits.
        for (int i = 0; i < 300; i++) begin
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            addr  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 63));
            wdata = $urandom;
            issue(we, size, uns, addr, wdata, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
